// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit BCD up/down counter with a programmable terminal value,
//   synchronous parallel load, wrap or saturate behaviour at the limits,
//   and cascade/overflow flags. Counts over 0..lim.
//
// Parameters
//   DIGITS : number of BCD digits (1..8)
//   WRAP   : 1 = wrap at the limits, 0 = hold at the limits
//
// Ports
//   clk : clock, rising edge
//   rst : synchronous active-high reset (q = 0, ovf = 0)
//   ce  : count enable, one step per cycle
//   dir : 1 = up, 0 = down
//   ld  : synchronous load strobe (priority over ce)
//   din : BCD load value, digit 0 in bits [3:0], digits > 9 clamp to 9
//   lim : BCD terminal value (upper bound of the range)
//   q   : registered BCD count
//   tc  : combinational terminal count, feeds ce of the next stage
//   ovf : registered one-cycle wrap/saturate event pulse
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  dir,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [4*DIGITS-1:0]   lim,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  ovf
);

    localparam int W       = 4 * DIGITS;
    localparam bit WRAP_EN = (WRAP != 0);

    // BCD increment: a digit steps only while every lower digit was 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement: a digit steps only while every lower digit was 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Load saturation: any non-decimal digit is forced to 9.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    logic         up_term;
    logic         dn_term;
    logic [W-1:0] q_nxt;
    logic         ovf_nxt;

    // Packed-nibble compare is decimal compare for valid BCD; q > lim
    // (only reachable via load) is treated as terminal.
    assign up_term = (q >= lim);
    assign dn_term = (q == '0);
    assign tc      = ce & (dir ? up_term : dn_term);

    always_comb begin
        q_nxt   = q;
        ovf_nxt = 1'b0;
        if (ld) begin
            q_nxt = bcd_clamp(din);
        end else if (ce) begin
            if (dir) begin
                if (up_term) begin
                    q_nxt   = WRAP_EN ? '0 : q;
                    ovf_nxt = 1'b1;
                end else begin
                    q_nxt = bcd_inc(q);
                end
            end else begin
                if (dn_term) begin
                    q_nxt   = WRAP_EN ? lim : q;
                    ovf_nxt = 1'b1;
                end else begin
                    q_nxt = bcd_dec(q);
                end
            end
        end
    end

    // Register stage: count and event pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // u_w: DIGITS=2, WRAP=1
    logic       w_rst = 1'b0, w_ce = 1'b0, w_dir = 1'b1, w_ld = 1'b0;
    logic [7:0] w_din = '0, w_lim = 8'h59;
    logic [7:0] w_q;
    logic       w_tc, w_ovf;

    // u_s: DIGITS=2, WRAP=0
    logic       s_rst = 1'b0, s_ce = 1'b0, s_dir = 1'b1, s_ld = 1'b0;
    logic [7:0] s_din = '0, s_lim = 8'h99;
    logic [7:0] s_q;
    logic       s_tc, s_ovf;

    // cascade: lo DIGITS=1 (lim 9) -> hi DIGITS=2 (lim 59)
    logic       c_rst = 1'b0, c_ce = 1'b0;
    logic [3:0] lo_q;
    logic       lo_tc, lo_ovf;
    logic [7:0] hi_q;
    logic       hi_tc, hi_ovf;

    bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_w (
        .clk(clk), .rst(w_rst), .ce(w_ce), .dir(w_dir), .ld(w_ld),
        .din(w_din), .lim(w_lim), .q(w_q), .tc(w_tc), .ovf(w_ovf)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_s (
        .clk(clk), .rst(s_rst), .ce(s_ce), .dir(s_dir), .ld(s_ld),
        .din(s_din), .lim(s_lim), .q(s_q), .tc(s_tc), .ovf(s_ovf)
    );

    bcd_updown_counter #(.DIGITS(1), .WRAP(1)) u_lo (
        .clk(clk), .rst(c_rst), .ce(c_ce), .dir(1'b1), .ld(1'b0),
        .din(4'h0), .lim(4'h9), .q(lo_q), .tc(lo_tc), .ovf(lo_ovf)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_hi (
        .clk(clk), .rst(c_rst), .ce(lo_tc), .dir(1'b1), .ld(1'b0),
        .din(8'h00), .lim(8'h59), .q(hi_q), .tc(hi_tc), .ovf(hi_ovf)
    );

    function automatic logic [7:0] to_bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        w_rst = 1'b1; w_ld = 1'b1; w_ce = 1'b1; w_din = 8'h55;
        s_rst = 1'b1; c_rst = 1'b1;
        tick();
        checks++;
        if (w_q !== 8'h00 || w_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset: q=%h ovf=%b, expected q=00 ovf=0", w_q, w_ovf);
        end
        checks++;
        if (s_q !== 8'h00 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_sat: q=%h ovf=%b, expected q=00 ovf=0", s_q, s_ovf);
        end
        w_rst = 1'b0; w_ld = 1'b0; w_ce = 1'b0;
        s_rst = 1'b0; c_rst = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_q   [3] = '{8'h58, 8'h59, 8'h00};
        logic       exp_ovf [3] = '{1'b0, 1'b0, 1'b1};
        logic       exp_tc  [3] = '{1'b0, 1'b1, 1'b0};
        w_lim = 8'h59; w_ld = 1'b1; w_din = 8'h57;
        tick();
        w_ld = 1'b0;
        checks++;
        if (w_q !== 8'h57) begin
            failures++;
            $display("FAIL up_wrap_load: q=%h, expected 57", w_q);
        end
        w_ce = 1'b1; w_dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (w_q !== exp_q[k] || w_ovf !== exp_ovf[k] || w_tc !== exp_tc[k]) begin
                failures++;
                $display("FAIL up_wrap[%0d]: q=%h ovf=%b tc=%b, expected q=%h ovf=%b tc=%b",
                         k, w_q, w_ovf, w_tc, exp_q[k], exp_ovf[k], exp_tc[k]);
            end
        end
        w_ce = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] eq;
        logic       eo;
        w_lim = 8'h23; w_ld = 1'b1; w_din = 8'h10;
        tick();
        w_ld = 1'b0; w_ce = 1'b1; w_dir = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 10) begin
                eq = to_bcd2(10 - k); eo = 1'b0;
            end else if (k == 11) begin
                eq = 8'h23; eo = 1'b1;
            end else begin
                eq = 8'h22; eo = 1'b0;
            end
            checks++;
            if (w_q !== eq || w_ovf !== eo) begin
                failures++;
                $display("FAIL down_wrap[%0d]: q=%h ovf=%b, expected q=%h ovf=%b",
                         k, w_q, w_ovf, eq, eo);
            end
            if (k == 10) begin
                checks++;
                if (w_tc !== 1'b1) begin
                    failures++;
                    $display("FAIL down_tc_at_zero: tc=%b, expected 1", w_tc);
                end
            end
        end
        w_ce = 1'b0;
    endtask

    task automatic test_saturate();
        logic       exp_ovf [3] = '{1'b0, 1'b1, 1'b1};
        s_lim = 8'h99; s_ld = 1'b1; s_din = 8'h98;
        tick();
        s_ld = 1'b0; s_ce = 1'b1; s_dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (s_q !== 8'h99 || s_ovf !== exp_ovf[k]) begin
                failures++;
                $display("FAIL saturate[%0d]: q=%h ovf=%b, expected q=99 ovf=%b",
                         k, s_q, s_ovf, exp_ovf[k]);
            end
        end
        s_dir = 1'b0;
        tick();
        s_ce = 1'b0;
        checks++;
        if (s_q !== 8'h98 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL saturate_down: q=%h ovf=%b, expected q=98 ovf=0", s_q, s_ovf);
        end
        // Hold at zero going down.
        s_ld = 1'b1; s_din = 8'h00;
        tick();
        s_ld = 1'b0; s_ce = 1'b1; s_dir = 1'b0;
        tick();
        s_ce = 1'b0;
        checks++;
        if (s_q !== 8'h00 || s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL saturate_zero: q=%h ovf=%b, expected q=00 ovf=1", s_q, s_ovf);
        end
    endtask

    task automatic test_load_clamp();
        w_lim = 8'h59; w_ld = 1'b1; w_din = 8'hA7;
        tick();
        w_ld = 1'b0;
        checks++;
        if (w_q !== 8'h97 || w_ovf !== 1'b0) begin
            failures++;
            $display("FAIL load_clamp: q=%h ovf=%b, expected q=97 ovf=0", w_q, w_ovf);
        end
        w_ce = 1'b1; w_dir = 1'b1;
        tick();
        checks++;
        if (w_q !== 8'h00 || w_ovf !== 1'b1) begin
            failures++;
            $display("FAIL over_limit_up: q=%h ovf=%b, expected q=00 ovf=1", w_q, w_ovf);
        end
        w_ld = 1'b1; w_din = 8'h42;
        tick();
        w_ld = 1'b0; w_ce = 1'b0;
        checks++;
        if (w_q !== 8'h42 || w_ovf !== 1'b0) begin
            failures++;
            $display("FAIL load_with_ce: q=%h ovf=%b, expected q=42 ovf=0", w_q, w_ovf);
        end
        w_ld = 1'b1; w_din = 8'hFF;
        tick();
        w_ld = 1'b0;
        checks++;
        if (w_q !== 8'h99) begin
            failures++;
            $display("FAIL load_clamp_ff: q=%h, expected 99", w_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4] = '{8'h31, 8'h30, 8'h31, 8'h32};
        logic       dirs  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        w_lim = 8'h59; w_ld = 1'b1; w_din = 8'h30;
        tick();
        w_ld = 1'b0; w_ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w_dir = dirs[k];
            tick();
            checks++;
            if (w_q !== exp_q[k]) begin
                failures++;
                $display("FAIL dir_change[%0d]: q=%h, expected %h", k, w_q, exp_q[k]);
            end
        end
        // Reset mid-count beats load and count.
        w_rst = 1'b1; w_ld = 1'b1; w_din = 8'h11;
        tick();
        w_rst = 1'b0; w_ld = 1'b0;
        checks++;
        if (w_q !== 8'h00 || w_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: q=%h ovf=%b, expected q=00 ovf=0", w_q, w_ovf);
        end
        tick();
        w_ce = 1'b0;
        checks++;
        if (w_q !== 8'h01) begin
            failures++;
            $display("FAIL resume_after_reset: q=%h, expected 01", w_q);
        end
    endtask

    task automatic test_lim_zero();
        w_lim = 8'h00; w_ld = 1'b1; w_din = 8'h00;
        tick();
        w_ld = 1'b0; w_dir = 1'b1; w_ce = 1'b0;
        #1;
        checks++;
        if (w_tc !== 1'b0) begin
            failures++;
            $display("FAIL lim0_tc_idle: tc=%b, expected 0", w_tc);
        end
        w_ce = 1'b1;
        #1;
        checks++;
        if (w_tc !== 1'b1) begin
            failures++;
            $display("FAIL lim0_tc: tc=%b, expected 1", w_tc);
        end
        for (int k = 0; k < 2; k++) begin
            w_dir = (k == 0);
            tick();
            checks++;
            if (w_q !== 8'h00 || w_ovf !== 1'b1) begin
                failures++;
                $display("FAIL lim0_step[%0d]: q=%h ovf=%b, expected q=00 ovf=1", k, w_q, w_ovf);
            end
        end
        w_ce = 1'b0;
        tick();
        checks++;
        if (w_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_not_sticky: ovf=%b, expected 0", w_ovf);
        end
    endtask

    task automatic test_cascade();
        int lo_pulses = 0;
        int hi_pulses = 0;
        int bad       = 0;
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_ce = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            tick();
            if (lo_ovf) lo_pulses++;
            if (hi_ovf) hi_pulses++;
            checks++;
            if (lo_q !== 4'(k % 10) || hi_q !== to_bcd2((k / 10) % 60) ||
                lo_ovf !== (k % 10 == 0) || hi_ovf !== (k % 600 == 0)) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL cascade[%0d]: hi=%h lo=%h ovf=%b%b, expected hi=%h lo=%h ovf=%b%b",
                             k, hi_q, lo_q, hi_ovf, lo_ovf, to_bcd2((k / 10) % 60),
                             4'(k % 10), (k % 600 == 0), (k % 10 == 0));
            end
        end
        c_ce = 1'b0;
        checks++;
        if (hi_pulses != 1 || lo_pulses != 60) begin
            failures++;
            $display("FAIL cascade_pulses: hi=%0d lo=%0d, expected hi=1 lo=60", hi_pulses, lo_pulses);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_clamp();
        test_back_to_back();
        test_lim_zero();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
